// File: rtl/phy_rx_sync_ctrl_if.sv
// Serial receive bundle between the PHY sampler and the sync controller.
// The slave side is the controller; the master side feeds data_in and observes results.
interface phy_rx_sync_ctrl_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;
    logic       aligned;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active,
        input  aligned
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active,
        output aligned
    );
endinterface

// File: rtl/phy_rx_sync_ctrl.sv
// Receive-side sync controller: bit-level COM hunt, byte alignment lock,
// then delivery of aligned bytes with COM bytes flagged as idle.
module phy_rx_sync_ctrl #(
    parameter logic [7:0]  COM_BYTE   = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic               clk_32f,
    input  logic               reset,
    phy_rx_sync_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    localparam logic [3:0] SYNC_LIM = 4'(SYNC_COUNT);
    localparam bit         SINGLE   = (SYNC_COUNT == 1);

    state_t     state;
    logic [7:0] sr;
    logic [7:0] sr_next;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
    logic [7:0] data_q;
    logic       valid_q;
    logic       strobe_q;
    logic       active_q;
    logic       aligned_q;
    logic       is_com;
    logic       boundary;

    assign sr_next  = {sr[6:0], bus.data_in};
    assign is_com   = (sr_next == COM_BYTE);
    assign boundary = (bit_cnt == 3'd7);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            com_cnt   <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            sr <= sr_next;
            case (state)
                SEARCH: begin
                    valid_q  <= 1'b0;
                    strobe_q <= 1'b0;
                    if (is_com) begin
                        // A hit here fixes the byte phase: the next sampled bit is bit 0 of a byte.
                        bit_cnt   <= 3'd0;
                        com_cnt   <= 4'd1;
                        aligned_q <= 1'b1;
                        if (SINGLE) begin
                            state    <= ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt <= com_cnt + 4'd1;
                            if ((com_cnt + 4'd1) == SYNC_LIM) begin
                                state    <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            state     <= SEARCH;
                            com_cnt   <= 4'd0;
                            aligned_q <= 1'b0;
                        end
                    end
                end

                ACTIVE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        data_q   <= sr_next;
                        strobe_q <= 1'b1;
                        valid_q  <= !is_com;
                    end else begin
                        strobe_q <= 1'b0;
                        valid_q  <= 1'b0;
                    end
                end

                default: begin
                    state     <= SEARCH;
                    com_cnt   <= 4'd0;
                    active_q  <= 1'b0;
                    aligned_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out    = data_q;
    assign bus.valid_out   = valid_q;
    assign bus.byte_strobe = strobe_q;
    assign bus.active      = active_q;
    assign bus.aligned     = aligned_q;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed bench for phy_rx_sync_ctrl: one default instance (SYNC_COUNT=4)
// and one single-COM instance (SYNC_COUNT=1) sharing clock and reset.
module tb_phy_rx_sync_ctrl;

    logic clk_32f;
    logic reset;
    int   vectors;
    int   miscompares;

    phy_rx_sync_ctrl_if if_a ();
    phy_rx_sync_ctrl_if if_b ();

    phy_rx_sync_ctrl #(.COM_BYTE(8'hBC), .SYNC_COUNT(4)) dut_a (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (if_a)
    );

    phy_rx_sync_ctrl #(.COM_BYTE(8'hBC), .SYNC_COUNT(1)) dut_b (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (if_b)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [3:0] stat_a;
    logic [3:0] stat_b;
    assign stat_a = {if_a.active, if_a.aligned, if_a.byte_strobe, if_a.valid_out};
    assign stat_b = {if_b.active, if_b.aligned, if_b.byte_strobe, if_b.valid_out};

    // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
    task automatic drive_bit(input logic bit_a, input logic bit_b);
        @(negedge clk_32f);
        reset       = 1'b0;
        if_a.data_in = bit_a;
        if_b.data_in = bit_b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk_32f);
        reset        = 1'b1;
        if_a.data_in = 1'($urandom_range(0, 1));
        if_b.data_in = 1'($urandom_range(0, 1));
        @(posedge clk_32f);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply_reset();
            vectors++;
            if ({stat_a, if_a.data_out, stat_b, if_b.data_out} !== 24'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold cycle %0d: got a=%b/%h b=%b/%h, expected all 0",
                         i, stat_a, if_a.data_out, stat_b, if_b.data_out);
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive_bit(1'b0, 1'b0);
            vectors++;
            if ({stat_a, if_a.data_out, stat_b, if_b.data_out} !== 24'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_idle cycle %0d: got a=%b/%h b=%b/%h, expected all 0",
                         i, stat_a, if_a.data_out, stat_b, if_b.data_out);
            end
        end
    endtask

    task automatic test_offset_lock();
        logic [7:0] com;
        logic [2:0] junk;
        logic [3:0] exp_stat;
        com  = 8'hBC;
        junk = 3'b101;
        apply_reset();
        for (int i = 2; i >= 0; i--) begin
            drive_bit(junk[i], 1'b0);
            vectors++;
            if (stat_a !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL lock_junk bit %0d: got %b, expected 0000", i, stat_a);
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 7; i >= 0; i--) begin
                drive_bit(com[i], 1'b0);
                exp_stat = {(k == 3 && i == 0), !(k == 0 && i != 0), 2'b00};
                vectors++;
                if (stat_a !== exp_stat || if_a.data_out !== 8'h00) begin
                    miscompares++;
                    $display("[TB] FAIL lock_com %0d bit %0d: got %b/%h, expected %b/00",
                             k, i, stat_a, if_a.data_out, exp_stat);
                end
            end
        end
    endtask

    task automatic test_active_data();
        logic [7:0] seq [3];
        logic [7:0] prev;
        logic [7:0] cur;
        logic [3:0] exp_stat;
        logic [7:0] exp_data;
        seq  = '{8'hFF, 8'hBC, 8'h3C};
        prev = 8'h00;
        for (int b = 0; b < 3; b++) begin
            cur = seq[b];
            for (int i = 7; i >= 0; i--) begin
                drive_bit(cur[i], 1'b0);
                if (i == 0) begin
                    exp_stat = {3'b111, (cur != 8'hBC)};
                    exp_data = cur;
                end else begin
                    exp_stat = 4'b1100;
                    exp_data = prev;
                end
                vectors++;
                if (stat_a !== exp_stat || if_a.data_out !== exp_data) begin
                    miscompares++;
                    $display("[TB] FAIL active_byte %0d bit %0d: got %b/%h, expected %b/%h",
                             b, i, stat_a, if_a.data_out, exp_stat, exp_data);
                end
            end
            prev = cur;
        end
    endtask

    task automatic test_broken_sync();
        logic [7:0] seq     [7];
        bit         mid_al  [7];
        bit         end_al  [7];
        logic [7:0] cur;
        logic [3:0] exp_stat;
        seq    = '{8'hBC, 8'hBC, 8'hB4, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        mid_al = '{0, 1, 1, 0, 1, 1, 1};
        end_al = '{1, 1, 0, 1, 1, 1, 1};
        apply_reset();
        for (int b = 0; b < 7; b++) begin
            cur = seq[b];
            for (int i = 7; i >= 0; i--) begin
                drive_bit(cur[i], 1'b0);
                if (i == 0)
                    exp_stat = {(b == 6), end_al[b], 2'b00};
                else
                    exp_stat = {1'b0, mid_al[b], 2'b00};
                vectors++;
                if (stat_a !== exp_stat) begin
                    miscompares++;
                    $display("[TB] FAIL broken_sync byte %0d bit %0d: got %b, expected %b",
                             b, i, stat_a, exp_stat);
                end
            end
        end
    endtask

    task automatic test_reset_mid_active();
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] com;
        logic [3:0] exp_stat;
        d0  = 8'h5A;
        d1  = 8'hC3;
        com = 8'hBC;
        for (int i = 7; i >= 0; i--) drive_bit(d0[i], 1'b0);
        vectors++;
        if (stat_a !== 4'b1111 || if_a.data_out !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_byte: got %b/%h, expected 1111/5a", stat_a, if_a.data_out);
        end
        for (int i = 7; i >= 4; i--) drive_bit(d1[i], 1'b0);
        apply_reset();
        vectors++;
        if (stat_a !== 4'b0000 || if_a.data_out !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL mid_active_reset: got %b/%h, expected 0000/00", stat_a, if_a.data_out);
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 7; i >= 0; i--) drive_bit(com[i], 1'b0);
            exp_stat = {(k == 3), 3'b100};
            vectors++;
            if (stat_a !== exp_stat || if_a.data_out !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL relock_com %0d: got %b/%h, expected %b/00",
                         k, stat_a, if_a.data_out, exp_stat);
            end
        end
    endtask

    task automatic test_sync1();
        logic [7:0] seq [3];
        logic [7:0] cur;
        logic [3:0] exp_stat;
        logic [7:0] exp_data;
        seq = '{8'hBC, 8'h7E, 8'hBC};
        apply_reset();
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        vectors++;
        if (stat_b !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL sync1_junk: got %b, expected 0000", stat_b);
        end
        for (int b = 0; b < 3; b++) begin
            cur = seq[b];
            for (int i = 7; i >= 0; i--) begin
                drive_bit(1'b0, cur[i]);
                if (b == 0) begin
                    exp_stat = (i == 0) ? 4'b1100 : 4'b0000;
                    exp_data = 8'h00;
                end else if (i == 0) begin
                    exp_stat = {3'b111, (cur != 8'hBC)};
                    exp_data = cur;
                end else begin
                    exp_stat = 4'b1100;
                    exp_data = (b == 1) ? 8'h00 : 8'h7E;
                end
                vectors++;
                if (stat_b !== exp_stat || if_b.data_out !== exp_data) begin
                    miscompares++;
                    $display("[TB] FAIL sync1_byte %0d bit %0d: got %b/%h, expected %b/%h",
                             b, i, stat_b, if_b.data_out, exp_stat, exp_data);
                end
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        if_a.data_in = 1'b0;
        if_b.data_in = 1'b0;
        test_reset();
        test_offset_lock();
        test_active_data();
        test_broken_sync();
        test_reset_mid_active();
        test_sync1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
